// File: rtl/reg_file_pkg.sv
// Shared constants, register-array type and read-select helper for the register file.
package reg_file_pkg;

  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;
  localparam int unsigned DATA_W   = 32;
  localparam int unsigned ZERO_IDX = 31;

  typedef logic [NUM_REGS-1:0][DATA_W-1:0] reg_array_t;

  // 32-to-1 selection of one register from the packed array.
  function automatic logic [DATA_W-1:0] reg_sel(input reg_array_t regs,
                                                input logic [ADDR_W-1:0] idx);
    return regs[idx];
  endfunction

endpackage

// File: rtl/decoder5_32.sv
// 5-to-32 one-hot write-enable decoder; all outputs low when enable is low.
module decoder5_32 (
  input  logic        enable,
  input  logic [4:0]  address,
  output logic [31:0] onehot
);

  always_comb begin
    onehot = '0;
    if (enable) begin
      onehot[address] = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_core.sv
// 32-entry, 2-read/1-write register file with a hardwired-zero register.
// Define REG_FILE_BYPASS_EN to forward same-cycle write data to the read ports.
module reg_file_core #(
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned ZERO_IDX = 31
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              RegWrite,
  input  logic [4:0]        WriteRegister,
  input  logic [DATA_W-1:0] WriteData,
  input  logic [4:0]        ReadRegister1,
  input  logic [4:0]        ReadRegister2,
  output logic [DATA_W-1:0] ReadData1,
  output logic [DATA_W-1:0] ReadData2
);

  import reg_file_pkg::*;

  localparam logic [4:0] ZeroAddr = 5'(ZERO_IDX);

  reg_array_t  regs_q;
  logic [31:0] wr_en;
  logic        wr_valid;

  // Writes to the zero register never reach the array, so it stays 0.
  assign wr_valid = RegWrite && (WriteRegister != ZeroAddr);

  decoder5_32 u_decoder (
    .enable  (wr_valid),
    .address (WriteRegister),
    .onehot  (wr_en)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      regs_q <= '0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        if (wr_en[i]) begin
          regs_q[i] <= WriteData;
        end
      end
    end
  end

`ifdef REG_FILE_BYPASS_EN
  logic fwd1, fwd2;

  assign fwd1 = wr_valid && !reset && (WriteRegister == ReadRegister1);
  assign fwd2 = wr_valid && !reset && (WriteRegister == ReadRegister2);

  always_comb begin
    ReadData1 = fwd1 ? WriteData : reg_sel(regs_q, ReadRegister1);
    ReadData2 = fwd2 ? WriteData : reg_sel(regs_q, ReadRegister2);
  end
`else
  always_comb begin
    ReadData1 = reg_sel(regs_q, ReadRegister1);
    ReadData2 = reg_sel(regs_q, ReadRegister2);
  end
`endif

endmodule

// File: tb/tb_reg_file_core.sv
// Randomized self-checking bench for reg_file_core against an array-based reference model.
module tb_reg_file_core;

  logic        clk;
  logic        reset;
  logic        RegWrite;
  logic [4:0]  WriteRegister;
  logic [31:0] WriteData;
  logic [4:0]  ReadRegister1;
  logic [4:0]  ReadRegister2;
  logic [31:0] ReadData1;
  logic [31:0] ReadData2;

  int unsigned checks = 0;
  int unsigned errors = 0;

  logic [31:0] model [32];
  logic [31:0] obs1, obs2;

  reg_file_core #(
    .DATA_W   (32),
    .ZERO_IDX (31)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .RegWrite      (RegWrite),
    .WriteRegister (WriteRegister),
    .WriteData     (WriteData),
    .ReadRegister1 (ReadRegister1),
    .ReadRegister2 (ReadRegister2),
    .ReadData1     (ReadData1),
    .ReadData2     (ReadData2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Expected read value from the architectural rules, given this cycle's inputs.
  function automatic logic [31:0] model_read(input logic [4:0] addr, input logic rst,
                                             input logic rw, input logic [4:0] wa,
                                             input logic [31:0] wd);
    if (addr == 5'd31) return 32'h0;
`ifdef REG_FILE_BYPASS_EN
    if (rw && !rst && wa == addr) return wd;
`endif
    return model[addr];
  endfunction

  // Drives one cycle, checks both read ports before the edge, then advances the model.
  task automatic step(input logic rst, input logic rw, input logic [4:0] wa,
                      input logic [31:0] wd, input logic [4:0] ra1, input logic [4:0] ra2,
                      input bit do_check);
    reset         = rst;
    RegWrite      = rw;
    WriteRegister = wa;
    WriteData     = wd;
    ReadRegister1 = ra1;
    ReadRegister2 = ra2;
    #2;
    obs1 = ReadData1;
    obs2 = ReadData2;
    if (do_check) begin
      check($sformatf("rd1[%0d]", ra1), obs1, model_read(ra1, rst, rw, wa, wd));
      check($sformatf("rd2[%0d]", ra2), obs2, model_read(ra2, rst, rw, wa, wd));
    end
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
    end else if (rw && wa != 5'd31) begin
      model[wa] = wd;
    end
    #1;
  endtask

  initial begin
    for (int i = 0; i < 32; i++) model[i] = 'x;
    reset = 1'b1; RegWrite = 1'b0; WriteRegister = '0; WriteData = '0;
    ReadRegister1 = '0; ReadRegister2 = '0;
    @(posedge clk); #1;

    // Reset clearing: one reset cycle, then every address on both ports reads zero.
    step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0);
    for (int a = 0; a < 32; a++) begin
      step(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a), 1'b1);
      check("reset_clear", obs1, 32'h0);
    end

    // Basic write/read on R5.
    step(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd1, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5, 1'b1);
    check("r5_port1", obs1, 32'hDEADBEEF);
    check("r5_port2", obs2, 32'hDEADBEEF);

    // Zero register ignores writes.
    step(1'b0, 1'b1, 5'd31, 32'h12345678, 5'd31, 5'd5, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd31, 5'd31, 1'b1);
    check("r31_zero", obs1, 32'h0);

    // Same-cycle read/write of R7.
    step(1'b0, 1'b1, 5'd7, 32'h1111, 5'd0, 5'd0, 1'b1);
    step(1'b0, 1'b1, 5'd7, 32'h2222, 5'd7, 5'd7, 1'b1);
`ifdef REG_FILE_BYPASS_EN
    check("r7_same_cycle", obs1, 32'h2222);
`else
    check("r7_same_cycle", obs1, 32'h1111);
`endif
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd7, 1'b1);
    check("r7_next_cycle", obs1, 32'h2222);

    // Reset beats a simultaneous write.
    step(1'b0, 1'b1, 5'd3, 32'h5A5A, 5'd3, 5'd3, 1'b1);
    step(1'b1, 1'b1, 5'd3, 32'hAAAA, 5'd3, 5'd3, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd7, 1'b1);
    check("r3_reset_prio", obs1, 32'h0);
    check("r7_after_reset", obs2, 32'h0);

    // Write-enable gating.
    step(1'b0, 1'b1, 5'd9, 32'h55, 5'd0, 5'd0, 1'b1);
    step(1'b0, 1'b0, 5'd9, 32'hFF, 5'd9, 5'd9, 1'b1);
    step(1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd9, 1'b1);
    check("r9_gated", obs1, 32'h55);

    // Randomized traffic with occasional mid-stream resets.
    for (int n = 0; n < 600; n++) begin
      step(($urandom_range(0, 39) == 0), ($urandom_range(0, 2) != 0),
           5'($urandom_range(0, 31)), $urandom,
           5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_core.md
REG_FILE_CORE -- requirements
Module: reg_file_core

Interface
REQ-001 SHALL have parameter DATA_W, default 32, register width in bits; only 32 is supported.
REQ-002 SHALL have parameter ZERO_IDX, default 31, index of the hardwired-zero register.
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-004 SHALL have port reset, input, 1, reset that is synchronous and active-high.
REQ-005 SHALL have port RegWrite, input, 1, write enable.
REQ-006 SHALL have port WriteRegister, input, 5, write address.
REQ-007 SHALL have port WriteData, input, DATA_W, write data.
REQ-008 SHALL have port ReadRegister1, input, 5, read address for port 1.
REQ-009 SHALL have port ReadRegister2, input, 5, read address for port 2.
REQ-010 SHALL have port ReadData1, output, DATA_W, read data for port 1.
REQ-011 SHALL have port ReadData2, output, DATA_W, read data for port 2.

Function
REQ-012 SHALL hold 32 registers of DATA_W bits each, indexed 0..31.
REQ-013 SHALL, at a rising clk edge with RegWrite=1 and reset=0, load WriteData into register WriteRegister.
REQ-014 SHALL leave every register unchanged when RegWrite=0.
REQ-015 SHALL ignore any write addressed to ZERO_IDX, which always reads as 0.
REQ-016 SHALL make read paths combinational with zero-cycle latency: ReadDataN = register[ReadRegisterN] in the same cycle.
REQ-017 SHALL allow both read ports to select the same register and return identical data.
REQ-018 SHALL, when a read and a write hit the same address in the same cycle without bypass, return the pre-edge value; the new value appears after the edge.
REQ-019 SHALL, when write and reset are asserted in the same cycle, give reset priority so that no write occurs.
REQ-020 SHALL treat all 5-bit addresses as valid and perform no range checking.

Reset
REQ-021 SHALL clear all 32 registers to 0 at a rising clk edge with reset=1.
REQ-022 SHALL therefore drive ReadData1 and ReadData2 to 0 from the cycle after reset until the first write.
REQ-023 SHALL, on reset asserted mid-stream, discard any pending write and clear all registers on that edge.

Configuration
REQ-024 SHALL use macro REG_FILE_BYPASS_EN; when defined, a read of address A while RegWrite=1, WriteRegister=A, A!=ZERO_IDX and reset=0 SHALL return WriteData combinationally for that port.
REQ-025 SHALL, without REG_FILE_BYPASS_EN, follow REQ-018 with no forwarding logic present.
REQ-026 SHALL NOT bypass for ZERO_IDX or while reset=1 in either configuration.

Structure
REQ-027 SHALL place NUM_REGS=32, ADDR_W=5, DATA_W=32, ZERO_IDX=31 and a reg-array typedef (32 x DATA_W packed) in shared package reg_file_pkg.
REQ-028 SHALL implement the 5-to-32 write-enable decode as sub-module decoder5_32 (inputs enable and 5-bit address, output one-hot 32-bit).
REQ-029 SHALL present the register array to the read paths as the packed 32 x 32 array type, selected by each 5-bit read address through a 32-to-1 selection.

Verification
REQ-030 SHALL verify reset clearing: reset for 1 cycle, then read all 32 addresses on both ports -> every read returns 0x00000000.
REQ-031 SHALL verify a basic write/read: write 0xDEADBEEF to R5, then next cycle ReadRegister1=5 and ReadRegister2=5 -> both ports return 0xDEADBEEF.
REQ-032 SHALL verify the zero register: write 0x12345678 to R31 -> ReadData1 at address 31 returns 0x00000000.
REQ-033 SHALL verify same-cycle read/write: R7=0x1111 and write 0x2222 to R7 while reading R7 -> 0x1111 without the macro, 0x2222 with it; both configurations read 0x2222 the next cycle.
REQ-034 SHALL verify reset priority: RegWrite=1 writing 0xAAAA to R3 together with reset=1 -> R3 reads 0x0 after the edge.
REQ-035 SHALL verify write enable gating: R9=0x55 and RegWrite=0 with WriteData=0xFF at R9 -> R9 still reads 0x55.
